// File: rtl/seg_scan_controller_if.sv
// Bus bundle between the scan controller and its surroundings. The controller
// sits on the slave modport; the host/decoder side uses the master modport.
interface seg_scan_controller_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              nibble;
  logic [6:0]              seg_in;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output data_in, load, digit_en, seg_in,
    input  nibble, seg, an, frame_done
  );

  modport slave (
    input  data_in, load, digit_en, seg_in,
    output nibble, seg, an, frame_done
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scan controller. One shared external decoder is
// fed a registered nibble; its active-low pattern is registered onto seg while
// the matching active-low anode is driven. Display data is double-buffered and
// only swapped at the frame boundary so a frame is never torn.
module seg_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset,
  seg_scan_controller_if.slave bus
);
  localparam int unsigned DataW  = 4 * NUM_DIGITS;
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntMax = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [6:0]  SegOff = 7'h7F;

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [3:0]            nibble_q, nibble_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;
  logic [DataW-1:0]      active_q, active_d;
  logic [DataW-1:0]      pending_q, pending_d;
  logic                  pend_valid_q, pend_valid_d;

  logic                  blank_last;
  logic                  show_last;
  logic                  last_digit;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] an_lit;

  assign blank_last = (state_q == StBlank) && (cnt_q == CntW'(BLANK_CYCLES - 1));
  assign show_last  = (state_q == StShow) && (cnt_q == CntW'(CLK_DIV - 1));
  assign last_digit = (idx_q == IdxW'(NUM_DIGITS - 1));
  assign boundary   = show_last && last_digit;

  // Anode pattern for the current digit, honouring the live digit enable.
  always_comb begin
    an_lit = '1;
    if (bus.digit_en[idx_q]) an_lit[idx_q] = 1'b0;
  end

  // Next-state: scan sequencing, output registers and display double-buffer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CntW'(1);
    nibble_d   = nibble_q;
    seg_d      = seg_q;
    an_d       = an_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pend_valid_d = pend_valid_q;
    // Registered one cycle early so the pulse lands on the last lit cycle.
    frame_done_d = (state_q == StShow) && last_digit && (cnt_q == CntW'(CLK_DIV - 2));

    // Buffer swap only at the frame boundary; a coincident load goes straight in.
    if (boundary) begin
      if (bus.load) begin
        active_d = bus.data_in;
      end else if (pend_valid_q) begin
        active_d = pending_q;
      end
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pending_d    = bus.data_in;
      pend_valid_d = 1'b1;
    end

    unique case (state_q)
      StBlank: begin
        seg_d = SegOff;
        an_d  = '1;
        if (blank_last) begin
          // nibble has been stable for the whole gap, so seg_in is settled.
          state_d = StShow;
          cnt_d   = '0;
          seg_d   = bus.seg_in;
          an_d    = an_lit;
        end
      end
      StShow: begin
        seg_d = bus.seg_in;
        an_d  = an_lit;
        if (show_last) begin
          state_d  = StBlank;
          cnt_d    = '0;
          idx_d    = last_digit ? '0 : idx_q + IdxW'(1);
          seg_d    = SegOff;
          an_d     = '1;
          nibble_d = active_d[int'(idx_d)*4 +: 4];
        end
      end
      default: state_d = StBlank;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBlank;
      idx_q        <= '0;
      cnt_q        <= '0;
      nibble_q     <= '0;
      seg_q        <= SegOff;
      an_q         <= '1;
      frame_done_q <= 1'b0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      nibble_q     <= nibble_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign bus.nibble     = nibble_q;
  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
